// File: rtl/rv32_mem_arbiter.sv
// Shares the single-port program/data RAM between the rv32 core and a host port.
// The host steals a cycle in RUN (core stalls one GAP cycle) or owns the RAM outright in HALT.
module rv32_mem_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  core_wr_en,
  input  logic [3:0]            core_wr_strobe,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [31:0]           core_wdata,
  output logic [31:0]           core_rdata,
  output logic                  core_stall,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_we,
  input  logic [3:0]            host_strobe,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [31:0]           host_wdata,
  output logic                  host_rvalid,
  output logic [31:0]           host_rdata,
  input  logic                  halt_req,
  output logic                  halt_ack,
  output logic                  ram_wr_en,
  output logic [3:0]            ram_wr_strobe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out
);

  typedef enum logic [1:0] {RUN, GAP, HALT} state_t;

  state_t state_q, state_d;
  logic   host_rvalid_q, host_rvalid_d;
  logic   host_sel;

  // A core write in RUN always wins over the host so it is never dropped.
  always_comb begin
    host_ready = 1'b0;
    if (reset_n) begin
      case (state_q)
        RUN:     host_ready = host_valid & ~core_wr_en;
        HALT:    host_ready = host_valid;
        default: host_ready = 1'b0;
      endcase
    end
  end

  assign host_sel = reset_n & (host_ready | (state_q == HALT));

  always_comb begin
    if (host_sel) begin
      ram_wr_en     = host_ready & host_we;
      ram_wr_strobe = host_strobe;
      ram_addr      = host_addr;
      ram_data_in   = host_wdata;
    end else begin
      ram_wr_en     = reset_n & core_wr_en & (state_q != HALT);
      ram_wr_strobe = core_wr_strobe;
      ram_addr      = core_addr;
      ram_data_in   = core_wdata;
    end
  end

  // Halt entry outranks the GAP transition; a host grant that same cycle still happens.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt_req & ~core_wr_en) state_d = HALT;
        else if (host_ready)        state_d = GAP;
      end
      GAP:     state_d = RUN;
      HALT:    if (!halt_req) state_d = GAP;
      default: state_d = RUN;
    endcase
  end

  assign host_rvalid_d = host_ready & ~host_we;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= RUN;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign core_stall  = (state_q != RUN);
  assign halt_ack    = (state_q == HALT);
  assign host_rvalid = host_rvalid_q;
  assign core_rdata  = ram_data_out;
  assign host_rdata  = ram_data_out;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter: RAM model, shadow memory and a read-data scoreboard.
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_wr_en;
  logic [3:0]  core_wr_strobe;
  logic [15:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [3:0]  host_strobe;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        halt_req;
  logic        halt_ack;
  logic        ram_wr_en;
  logic [3:0]  ram_wr_strobe;
  logic [15:0] ram_addr;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out = 32'h0;

  logic [31:0] mem    [0:65535];
  logic [31:0] expMem [0:65535];
  logic [31:0] expQ   [$];

  int total = 0;
  int bad   = 0;

  rv32_mem_arbiter #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_wr_en(core_wr_en), .core_wr_strobe(core_wr_strobe), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_strobe(host_strobe), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .ram_wr_en(ram_wr_en), .ram_wr_strobe(ram_wr_strobe), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Byte-strobed synchronous RAM, read data one cycle after its address.
  always @(posedge clk) begin
    if (ram_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wr_strobe[b]) mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
    end
    ram_data_out <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic hreq,
                               input logic cwe, input logic [3:0] cstrb,
                               input logic [15:0] caddr, input logic [31:0] cwdata,
                               input logic hv, input logic hwe, input logic [3:0] hstrb,
                               input logic [15:0] haddr, input logic [31:0] hwdata);
    @(posedge clk);
    #1;
    reset_n = rst; halt_req = hreq;
    core_wr_en = cwe; core_wr_strobe = cstrb; core_addr = caddr; core_wdata = cwdata;
    host_valid = hv; host_we = hwe; host_strobe = hstrb; host_addr = haddr; host_wdata = hwdata;
  endtask

  task automatic idleCycle(input logic hreq);
    applyStimulus(1'b1, hreq, 1'b0, 4'h0, 16'h0100, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  // Scoreboard: every host read the bench expects to be granted pushes its data; rvalid pops it.
  always @(negedge clk) begin
    if (host_rvalid) begin
      if (expQ.size() == 0) checkOutput("rvalid_unexpected", 32'(host_rvalid), 32'h0);
      else                  checkOutput("host_rdata", host_rdata, expQ.pop_front());
    end
    checkOutput("core_rdata_pass", core_rdata, ram_data_out);
  end

  initial begin
    mem[16'h0040] = 32'h12345678; expMem[16'h0040] = 32'h12345678;
    mem[16'h0100] = 32'hC0DE0100; expMem[16'h0100] = 32'hC0DE0100;
    mem[16'h0200] = 32'h00200200; expMem[16'h0200] = 32'h00200200;

    reset_n = 1'b0; halt_req = 1'b1;
    core_wr_en = 1'b0; core_wr_strobe = 4'h0; core_addr = 16'h0100; core_wdata = 32'h0;
    host_valid = 1'b1; host_we = 1'b1; host_strobe = 4'hF; host_addr = 16'h0055; host_wdata = 32'h5A5A5A5A;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("rst_host_ready", 32'(host_ready), 32'h0);
      checkOutput("rst_ram_wr_en", 32'(ram_wr_en), 32'h0);
      checkOutput("rst_core_stall", 32'(core_stall), 32'h0);
      checkOutput("rst_halt_ack", 32'(halt_ack), 32'h0);
      checkOutput("rst_ram_addr", 32'(ram_addr), 32'h0100);
    end

    // Single host read stealing one cycle from the core.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 16'h0100, 32'h0, 1'b1, 1'b0, 4'hF, 16'h0040, 32'h0);
    expQ.push_back(expMem[16'h0040]);
    @(negedge clk);
    checkOutput("rd_host_ready", 32'(host_ready), 32'h1);
    checkOutput("rd_ram_addr", 32'(ram_addr), 32'h0040);
    checkOutput("rd_ram_wr_en", 32'(ram_wr_en), 32'h0);
    checkOutput("rd_stall_n", 32'(core_stall), 32'h0);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("rd_stall_n1", 32'(core_stall), 32'h1);
    checkOutput("rd_rvalid_n1", 32'(host_rvalid), 32'h1);
    checkOutput("rd_core_addr_n1", 32'(ram_addr), 32'h0100);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("rd_stall_n2", 32'(core_stall), 32'h0);
    checkOutput("rd_core_rdata_n2", core_rdata, 32'hC0DE0100);

    // Core write collides with a host request: core wins, host follows next cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 1'b1, 1'b0, 4'hF, 16'h0010, 32'h0);
    expMem[16'h0010] = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("col_host_ready", 32'(host_ready), 32'h0);
    checkOutput("col_ram_wr_en", 32'(ram_wr_en), 32'h1);
    checkOutput("col_ram_addr", 32'(ram_addr), 32'h0010);
    checkOutput("col_ram_data", ram_data_in, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 16'h0100, 32'h0, 1'b1, 1'b0, 4'hF, 16'h0010, 32'h0);
    expQ.push_back(expMem[16'h0010]);
    @(negedge clk);
    checkOutput("col_host_next", 32'(host_ready), 32'h1);
    checkOutput("col_mem", mem[16'h0010], 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h3, 16'h0010, 32'h11112222, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    expMem[16'h0010] = 32'hDEAD2222;
    @(negedge clk);
    checkOutput("gap_stall", 32'(core_stall), 32'h1);
    checkOutput("gap_wr_en", 32'(ram_wr_en), 32'h1);
    checkOutput("gap_strobe", 32'(ram_wr_strobe), 32'h3);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("gap_mem", mem[16'h0010], expMem[16'h0010]);

    // Host holds valid for 6 cycles: grants alternate with GAP cycles.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 16'h0100, 32'h0, 1'b1, 1'b0, 4'hF, 16'h0040, 32'h0);
      if (i % 2 == 0) expQ.push_back(expMem[16'h0040]);
      @(negedge clk);
      checkOutput("b2b_ready", 32'(host_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput("b2b_stall", 32'(core_stall), (i % 2 == 1) ? 32'h1 : 32'h0);
    end
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("b2b_release", 32'(core_stall), 32'h0);

    // Halt request deferred by a core write, then granted together with a host read.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 16'h0300, 32'h33333333, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    expMem[16'h0300] = 32'h33333333;
    @(negedge clk);
    checkOutput("hd_ram_wr_en", 32'(ram_wr_en), 32'h1);
    checkOutput("hd_ram_addr", 32'(ram_addr), 32'h0300);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 16'h0100, 32'h0, 1'b1, 1'b0, 4'hF, 16'h0040, 32'h0);
    expQ.push_back(expMem[16'h0040]);
    @(negedge clk);
    checkOutput("hd_deferred_ack", 32'(halt_ack), 32'h0);
    checkOutput("hd_host_ready", 32'(host_ready), 32'h1);

    // Bulk load in HALT while the core keeps presenting a write that must not land.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 16'h0200, 32'h55555555, 1'b1, 1'b1, 4'hF, 16'(i), 32'hA0 + 32'(i));
      expMem[i] = 32'hA0 + 32'(i);
      @(negedge clk);
      checkOutput("hl_ack", 32'(halt_ack), 32'h1);
      checkOutput("hl_stall", 32'(core_stall), 32'h1);
      checkOutput("hl_ready", 32'(host_ready), 32'h1);
      checkOutput("hl_wr_en", 32'(ram_wr_en), 32'h1);
      checkOutput("hl_addr", 32'(ram_addr), 32'(i));
      checkOutput("hl_data", ram_data_in, 32'hA0 + 32'(i));
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 16'h0200, 32'h55555555, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    @(negedge clk);
    checkOutput("hl_core_blocked", 32'(ram_wr_en), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 16'h0100, 32'h0, 1'b1, 1'b0, 4'hF, 16'(i), 32'h0);
      expQ.push_back(expMem[i]);
      @(negedge clk);
      checkOutput("hl_rd_ready", 32'(host_ready), 32'h1);
    end

    // Drop halt with a final read in flight: GAP returns it, then RUN.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 16'h0100, 32'h0, 1'b1, 1'b0, 4'hF, 16'h0007, 32'h0);
    expQ.push_back(expMem[7]);
    @(negedge clk);
    checkOutput("hx_ack_m", 32'(halt_ack), 32'h1);
    checkOutput("hx_ready_m", 32'(host_ready), 32'h1);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("hx_ack_gap", 32'(halt_ack), 32'h0);
    checkOutput("hx_stall_gap", 32'(core_stall), 32'h1);
    checkOutput("hx_rvalid_gap", 32'(host_rvalid), 32'h1);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("hx_stall_run", 32'(core_stall), 32'h0);
    checkOutput("hx_core_write_held", mem[16'h0200], expMem[16'h0200]);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 16'h0100, 32'h0, 1'b1, 1'b0, 4'hF, 16'(i), 32'h0);
      expQ.push_back(expMem[i]);
      @(negedge clk);
      checkOutput("rb_ready", 32'(host_ready), 32'h1);
      idleCycle(1'b0);
      @(negedge clk);
      checkOutput("rb_stall", 32'(core_stall), 32'h1);
    end

    // Reset while in HALT with a host read being presented.
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("rm_ack_pre", 32'(halt_ack), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 16'h0100, 32'h0, 1'b1, 1'b0, 4'hF, 16'h0040, 32'h0);
    expQ.push_back(expMem[16'h0040]);
    @(negedge clk);
    checkOutput("rm_ack", 32'(halt_ack), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 16'h0100, 32'h0, 1'b1, 1'b0, 4'hF, 16'h0003, 32'h0);
    @(negedge clk);
    checkOutput("rm_ready_rst", 32'(host_ready), 32'h0);
    checkOutput("rm_wr_en_rst", 32'(ram_wr_en), 32'h0);
    checkOutput("rm_addr_rst", 32'(ram_addr), 32'h0100);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("rm_ack_post", 32'(halt_ack), 32'h0);
    checkOutput("rm_stall_post", 32'(core_stall), 32'h0);
    checkOutput("rm_rvalid_post", 32'(host_rvalid), 32'h0);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("sb_drained", 32'(expQ.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
